// File: rtl/trap_controller.sv
// Machine-mode trap unit: takes exceptions, external interrupts and MRET at retire, holds the trap CSRs,
// and drives the next-PC redirect plus a pipeline stall. Define TRAP_VECTORED_EN for vectored mtvec mode.
module trap_controller #(
    parameter logic [31:0] MTVEC_RESET  = 32'h0000_0004,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        I_clk,
    input  logic        I_rst,
    input  logic        I_valid,
    input  logic [31:0] I_pc,
    input  logic        I_illegal,
    input  logic        I_ecall,
    input  logic        I_ebreak,
    input  logic        I_misalign,
    input  logic [31:0] I_badaddr,
    input  logic        I_mret,
    input  logic        I_irq_ext,
    input  logic        I_csr_we,
    input  logic [11:0] I_csr_addr,
    input  logic [31:0] I_csr_wdata,
    output logic [31:0] O_csr_rdata,
    output logic        O_exception,
    output logic        O_privsel,
    output logic [31:0] O_mevect,
    output logic [31:0] O_mepc,
    output logic        O_stall
);

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    localparam logic [31:0] CAUSE_IRQ_EXT = 32'h8000_000B;
    localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;
    localparam logic [31:0] CAUSE_ECALL   = 32'd11;
    localparam logic [31:0] CAUSE_EBREAK  = 32'd3;
    localparam logic [31:0] CAUSE_MISALGN = 32'd4;

    // TRAP/RETURN already account for one stall cycle; FLUSH covers the rest.
    localparam int unsigned FLUSH_LOAD_I = (FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0;
    localparam logic [2:0]  FLUSH_LOAD   = 3'(FLUSH_LOAD_I);
    localparam logic        HAS_FLUSH    = (FLUSH_CYCLES > 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_TRAP,
        S_RETURN,
        S_FLUSH
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        mst_mie_q, mst_mie_d;
    logic        mst_mpie_q, mst_mpie_d;
    logic        meie_q, meie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mtval_q, mtval_d;

    logic        retire;
    logic        irq_take;
    logic        exc_any;
    logic        trap_take;
    logic        mret_take;
    logic        csr_wr;
    logic [31:0] trap_cause;
    logic [31:0] trap_tval;
    logic [31:0] mtvec_base;
    logic [31:0] trap_target;

    assign retire    = (state_q == S_IDLE) && I_valid;
    assign irq_take  = I_irq_ext && mst_mie_q && meie_q;
    assign exc_any   = I_illegal || I_ecall || I_ebreak || I_misalign;
    assign trap_take = retire && (irq_take || exc_any);
    assign mret_take = retire && I_mret && !irq_take && !exc_any;
    assign csr_wr    = (state_q == S_IDLE) && I_csr_we && !trap_take && !mret_take;

    always_comb begin
        trap_cause = CAUSE_MISALGN;
        trap_tval  = I_badaddr;
        if (irq_take) begin
            trap_cause = CAUSE_IRQ_EXT;
            trap_tval  = '0;
        end else if (I_illegal) begin
            trap_cause = CAUSE_ILLEGAL;
            trap_tval  = '0;
        end else if (I_ecall) begin
            trap_cause = CAUSE_ECALL;
            trap_tval  = '0;
        end else if (I_ebreak) begin
            trap_cause = CAUSE_EBREAK;
            trap_tval  = '0;
        end
    end

    assign mtvec_base = mtvec_q & 32'hFFFF_FFFC;

`ifdef TRAP_VECTORED_EN
    // Only interrupts are vectored; synchronous exceptions always land on the base.
    assign trap_target = (mcause_q[31] && (mtvec_q[1:0] == 2'b01))
                       ? mtvec_base + {mcause_q[29:0], 2'b00}
                       : mtvec_base;
`else
    assign trap_target = mtvec_base;
`endif

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through the case infers a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        mst_mie_d  = mst_mie_q;
        mst_mpie_d = mst_mpie_q;
        meie_d     = meie_q;
        mtvec_d    = mtvec_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;

        unique case (state_q)
            S_IDLE: begin
                if (trap_take) begin
                    state_d    = S_TRAP;
                    mepc_d     = I_pc & 32'hFFFF_FFFC;
                    mcause_d   = trap_cause;
                    mtval_d    = trap_tval;
                    mst_mpie_d = mst_mie_q;
                    mst_mie_d  = 1'b0;
                end else if (mret_take) begin
                    state_d    = S_RETURN;
                    mst_mie_d  = mst_mpie_q;
                    mst_mpie_d = 1'b1;
                end else if (csr_wr) begin
                    unique case (I_csr_addr)
                        CSR_MSTATUS: begin
                            mst_mie_d  = I_csr_wdata[3];
                            mst_mpie_d = I_csr_wdata[7];
                        end
                        CSR_MIE:    meie_d   = I_csr_wdata[11];
`ifdef TRAP_VECTORED_EN
                        CSR_MTVEC:  mtvec_d  = I_csr_wdata;
`else
                        CSR_MTVEC:  mtvec_d  = I_csr_wdata & 32'hFFFF_FFFC;
`endif
                        CSR_MEPC:   mepc_d   = I_csr_wdata & 32'hFFFF_FFFC;
                        CSR_MCAUSE: mcause_d = I_csr_wdata;
                        CSR_MTVAL:  mtval_d  = I_csr_wdata;
                        default: ;
                    endcase
                end
            end
            S_TRAP, S_RETURN: begin
                if (HAS_FLUSH) begin
                    state_d = S_FLUSH;
                    cnt_d   = FLUSH_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FLUSH: begin
                if (cnt_q == 3'd0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 3'd0;
            mst_mie_q  <= 1'b0;
            mst_mpie_q <= 1'b0;
            meie_q     <= 1'b0;
            mtvec_q    <= MTVEC_RESET;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mst_mie_q  <= mst_mie_d;
            mst_mpie_q <= mst_mpie_d;
            meie_q     <= meie_d;
            mtvec_q    <= mtvec_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
        end
    end

    // Read port is forced to zero while reset is held so every output is quiet in reset.
    always_comb begin
        O_csr_rdata = '0;
        if (!I_rst) begin
            unique case (I_csr_addr)
                CSR_MSTATUS: O_csr_rdata = {24'b0, mst_mpie_q, 3'b0, mst_mie_q, 3'b0};
                CSR_MIE:     O_csr_rdata = {20'b0, meie_q, 11'b0};
                CSR_MTVEC:   O_csr_rdata = mtvec_q;
                CSR_MEPC:    O_csr_rdata = mepc_q;
                CSR_MCAUSE:  O_csr_rdata = mcause_q;
                CSR_MTVAL:   O_csr_rdata = mtval_q;
                CSR_MIP:     O_csr_rdata = {20'b0, I_irq_ext, 11'b0};
                default:     O_csr_rdata = '0;
            endcase
        end
    end

    assign O_exception = (state_q == S_TRAP);
    assign O_privsel   = (state_q == S_RETURN);
    assign O_stall     = (state_q != S_IDLE);
    assign O_mevect    = (state_q == S_TRAP) ? trap_target : 32'h0;
    assign O_mepc      = mepc_q;

endmodule

// File: tb/tb_trap_controller.sv
// Self-checking bench for trap_controller: redirect expectations are queued when a retire is driven
// and compared by a monitor when the DUT pulses O_exception / O_privsel.
module tb_trap_controller;

    localparam logic [4:0] F_ILL  = 5'b00001;
    localparam logic [4:0] F_EC   = 5'b00010;
    localparam logic [4:0] F_EB   = 5'b00100;
    localparam logic [4:0] F_MIS  = 5'b01000;
    localparam logic [4:0] F_MRET = 5'b10000;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid, illegal, ecall, ebreak, misalign, mret, irq_ext, csr_we;
    logic [31:0] pc, badaddr, csr_wdata;
    logic [11:0] csr_addr;
    logic [31:0] csr_rdata, mevect, mepc;
    logic        exception, privsel, stall;

    typedef struct {
        logic        exc;
        logic        priv;
        logic [31:0] vect;
        logic [31:0] mepc;
    } redir_t;

    redir_t sb_q[$];
    redir_t mon_r;
    int     n_checks = 0;
    int     n_pass   = 0;
    int     n;

    always #5 clk = ~clk;

    trap_controller dut (
        .I_clk      (clk),
        .I_rst      (rst),
        .I_valid    (valid),
        .I_pc       (pc),
        .I_illegal  (illegal),
        .I_ecall    (ecall),
        .I_ebreak   (ebreak),
        .I_misalign (misalign),
        .I_badaddr  (badaddr),
        .I_mret     (mret),
        .I_irq_ext  (irq_ext),
        .I_csr_we   (csr_we),
        .I_csr_addr (csr_addr),
        .I_csr_wdata(csr_wdata),
        .O_csr_rdata(csr_rdata),
        .O_exception(exception),
        .O_privsel  (privsel),
        .O_mevect   (mevect),
        .O_mepc     (mepc),
        .O_stall    (stall)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic push_exp(input logic exc, input logic priv, input logic [31:0] vect,
                            input logic [31:0] epc);
        redir_t r;
        r.exc  = exc;
        r.priv = priv;
        r.vect = vect;
        r.mepc = epc;
        sb_q.push_back(r);
    endtask

    always @(negedge clk) begin
        if (!rst && (exception || privsel)) begin
            check("redir_onehot", {31'b0, exception & privsel}, 32'd0);
            if (sb_q.size() == 0) begin
                check("redir_unexpected", {31'b0, exception}, {31'b0, privsel});
                check("redir_unexpected_any", 32'd1, 32'd0);
            end else begin
                mon_r = sb_q.pop_front();
                check("redir_exc", {31'b0, exception}, {31'b0, mon_r.exc});
                check("redir_priv", {31'b0, privsel}, {31'b0, mon_r.priv});
                check("redir_mepc", mepc, mon_r.mepc);
                if (mon_r.exc) check("redir_mevect", mevect, mon_r.vect);
            end
        end
    end

    task automatic retire(input logic [31:0] rpc, input logic [4:0] flags,
                          input logic [31:0] bad = 32'h0, input logic we = 1'b0,
                          input logic [11:0] waddr = 12'h0, input logic [31:0] wdata = 32'h0);
        @(negedge clk);
        valid     = 1'b1;
        pc        = rpc;
        illegal   = flags[0];
        ecall     = flags[1];
        ebreak    = flags[2];
        misalign  = flags[3];
        mret      = flags[4];
        badaddr   = bad;
        csr_we    = we;
        csr_addr  = waddr;
        csr_wdata = wdata;
        @(posedge clk);
        #1;
        valid    = 1'b0;
        illegal  = 1'b0;
        ecall    = 1'b0;
        ebreak   = 1'b0;
        misalign = 1'b0;
        mret     = 1'b0;
        csr_we   = 1'b0;
    endtask

    // Counts stalled cycles from now until O_stall drops, bounded.
    task automatic stall_len(output int cnt);
        cnt = 0;
        while (stall && cnt < 16) begin
            cnt++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
        @(negedge clk);
        csr_we    = 1'b1;
        csr_addr  = addr;
        csr_wdata = data;
        @(posedge clk);
        #1;
        csr_we = 1'b0;
    endtask

    task automatic chk_csr(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        csr_addr = addr;
        #1;
        check(tag, csr_rdata, exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        {valid, illegal, ecall, ebreak, misalign, mret, irq_ext, csr_we} = '0;
        pc = '0; badaddr = '0; csr_wdata = '0; csr_addr = 12'h305;
        repeat (2) @(posedge clk);
        #1;
        check("rst_exception", {31'b0, exception}, 32'd0);
        check("rst_privsel", {31'b0, privsel}, 32'd0);
        check("rst_stall", {31'b0, stall}, 32'd0);
        check("rst_mevect", mevect, 32'd0);
        check("rst_mepc", mepc, 32'd0);
        check("rst_rdata", csr_rdata, 32'd0);
        rst = 1'b0;
        #1;
        chk_csr("rst_mtvec", 12'h305, 32'h0000_0004);
        chk_csr("rst_mstatus", 12'h300, 32'h0);
        chk_csr("unmapped_rd", 12'h7C0, 32'h0);

        // ECALL with MIE set
        csr_write(12'h300, 32'h0000_0008);
        csr_write(12'h7C0, 32'hFFFF_FFFF);
        chk_csr("unmapped_wr", 12'h7C0, 32'h0);
        chk_csr("mstatus_wr", 12'h300, 32'h0000_0008);
        push_exp(1'b1, 1'b0, 32'h4, 32'h100);
        retire(32'h100, F_EC);
        stall_len(n);
        check("ecall_stall", n, 32'd2);
        chk_csr("ecall_mepc", 12'h341, 32'h100);
        chk_csr("ecall_mcause", 12'h342, 32'd11);
        chk_csr("ecall_mtval", 12'h343, 32'd0);
        chk_csr("ecall_mstatus", 12'h300, 32'h80);
        check("ecall_o_mepc", mepc, 32'h100);

        // Priority among synchronous exceptions
        push_exp(1'b1, 1'b0, 32'h4, 32'h300);
        retire(32'h300, F_ILL | F_MIS, 32'h2003);
        stall_len(n);
        chk_csr("illmis_mcause", 12'h342, 32'd2);
        chk_csr("illmis_mtval", 12'h343, 32'd0);
        push_exp(1'b1, 1'b0, 32'h4, 32'h304);
        retire(32'h304, F_MIS, 32'h2003);
        stall_len(n);
        chk_csr("mis_mcause", 12'h342, 32'd4);
        chk_csr("mis_mtval", 12'h343, 32'h2003);
        push_exp(1'b1, 1'b0, 32'h4, 32'h308);
        retire(32'h308, F_EC | F_EB | F_MIS, 32'h2003);
        stall_len(n);
        chk_csr("ecbk_mcause", 12'h342, 32'd11);
        chk_csr("ecbk_mtval", 12'h343, 32'd0);
        push_exp(1'b1, 1'b0, 32'h4, 32'h30C);
        retire(32'h30C, F_EB);
        stall_len(n);
        chk_csr("ebreak_mcause", 12'h342, 32'd3);

        // External interrupt
        csr_write(12'h304, 32'hFFFF_FFFF);
        chk_csr("mie_mask", 12'h304, 32'h800);
        csr_write(12'h300, 32'hFFFF_FFFF);
        chk_csr("mstatus_mask", 12'h300, 32'h88);
        csr_write(12'h300, 32'h0000_0008);
        irq_ext = 1'b1;
        chk_csr("mip_meip", 12'h344, 32'h800);
        push_exp(1'b1, 1'b0, 32'h4, 32'h200);
        retire(32'h200, 5'b0);
        stall_len(n);
        check("irq_stall", n, 32'd2);
        chk_csr("irq_mcause", 12'h342, 32'h8000_000B);
        chk_csr("irq_mtval", 12'h343, 32'd0);
        chk_csr("irq_mepc", 12'h341, 32'h200);
        chk_csr("irq_mstatus", 12'h300, 32'h80);

        // MIE=0 masks the interrupt
        retire(32'h204, 5'b0);
        stall_len(n);
        check("irq_masked_stall", n, 32'd0);
        chk_csr("irq_masked_mepc", 12'h341, 32'h200);

        // MRET with a colliding mepc write
        push_exp(1'b0, 1'b1, 32'h0, 32'h200);
        retire(32'h208, F_MRET, 32'h0, 1'b1, 12'h341, 32'hDEAD_0000);
        stall_len(n);
        check("mret_stall", n, 32'd2);
        chk_csr("mret_mstatus", 12'h300, 32'h88);
        chk_csr("mret_mepc", 12'h341, 32'h200);
        check("mret_o_mepc", mepc, 32'h200);

        // Interrupt dropped before retire, then interrupt beating ECALL
        irq_ext = 1'b0;
        retire(32'h20C, 5'b0);
        stall_len(n);
        check("irq_drop_stall", n, 32'd0);
        irq_ext = 1'b1;
        push_exp(1'b1, 1'b0, 32'h4, 32'h210);
        retire(32'h210, F_EC);
        stall_len(n);
        irq_ext = 1'b0;
        chk_csr("irq_ec_mcause", 12'h342, 32'h8000_000B);

        // CSR write and retire outside IDLE are ignored
        push_exp(1'b1, 1'b0, 32'h4, 32'h400);
        retire(32'h400, F_EC);
        csr_write(12'h343, 32'h0000_0055);
        stall_len(n);
        check("busy_stall", n, 32'd1);
        chk_csr("busy_mtval", 12'h343, 32'd0);
        push_exp(1'b1, 1'b0, 32'h4, 32'h404);
        retire(32'h404, F_EC);
        retire(32'h408, F_ILL);
        stall_len(n);
        chk_csr("busy_retire_mepc", 12'h341, 32'h404);

        // Reset in the middle of FLUSH
        push_exp(1'b1, 1'b0, 32'h4, 32'h500);
        retire(32'h500, F_EC);
        @(posedge clk);
        #1;
        check("flush_stall", {31'b0, stall}, 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_stall", {31'b0, stall}, 32'd0);
        check("midrst_mepc", mepc, 32'd0);
        check("midrst_rdata", csr_rdata, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk_csr("midrst_mtvec", 12'h305, 32'h4);
        chk_csr("midrst_mcause", 12'h342, 32'h0);
        chk_csr("midrst_mstatus", 12'h300, 32'h0);

        // mtvec mode bits
        csr_write(12'h305, 32'h0000_1001);
`ifdef TRAP_VECTORED_EN
        chk_csr("vec_mtvec", 12'h305, 32'h1001);
        csr_write(12'h304, 32'h800);
        csr_write(12'h300, 32'h8);
        irq_ext = 1'b1;
        push_exp(1'b1, 1'b0, 32'h102C, 32'h600);
        retire(32'h600, 5'b0);
        stall_len(n);
        irq_ext = 1'b0;
        push_exp(1'b1, 1'b0, 32'h1000, 32'h604);
        retire(32'h604, F_EC);
        stall_len(n);
`else
        chk_csr("novec_mtvec", 12'h305, 32'h1000);
        push_exp(1'b1, 1'b0, 32'h1000, 32'h600);
        retire(32'h600, F_EC);
        stall_len(n);
`endif

        repeat (2) @(posedge clk);
        #1;
        check("sb_drain", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/trap_controller.md
Name: trap_controller

Overview:
- Machine-mode trap unit: detects synchronous exceptions, external interrupts and MRET at instruction retire; holds the trap CSRs.
- Drives the select and address inputs of the next-PC privilege multiplexor:
  - O_exception: selects trap vector.
  - O_privsel: selects mepc on return.
  - O_mevect: trap vector address.
- Stalls the pipeline while the redirect drains.

Parameters:
- MTVEC_RESET, 32'h0000_0004, reset value of mtvec.
- FLUSH_CYCLES, 2, stall cycles after a redirect (1..7).

Ports:
- I_clk  in  1  clock, rising edge.
- I_rst  in  1  reset, asynchronous, active-high.
- I_valid  in  1  instruction retiring this cycle.
- I_pc  in  32  PC of retiring instruction.
- I_illegal  in  1  illegal instruction.
- I_ecall  in  1  ECALL.
- I_ebreak  in  1  EBREAK.
- I_misalign  in  1  misaligned load/store.
- I_badaddr  in  32  faulting address for I_misalign.
- I_mret  in  1  MRET.
- I_irq_ext  in  1  external interrupt, level.
- I_csr_we  in  1  CSR write strobe.
- I_csr_addr  in  12  CSR address.
- I_csr_wdata  in  32  CSR write data.
- O_csr_rdata  out  32  combinational CSR read data.
- O_exception  out  1  trap redirect pulse.
- O_privsel  out  1  MRET redirect pulse.
- O_mevect  out  32  trap target.
- O_mepc  out  32  current mepc.
- O_stall  out  1  pipeline hold.

Behaviour:
- Reset values: all outputs 0; mstatus, mie, mepc, mcause, mtval = 0; mtvec = MTVEC_RESET; state = IDLE.
- Reset mid-sequence aborts to IDLE immediately, with no CSR side effects.
- CSR map:
  - 0x300 mstatus: only MIE[3] and MPIE[7] writable; other bits read 0.
  - 0x304 mie: only MEIE[11] writable.
  - 0x305 mtvec.
  - 0x341 mepc: [1:0] hardwired 0.
  - 0x342 mcause.
  - 0x343 mtval.
  - 0x344 mip: read-only, MEIP[11] = I_irq_ext.
  - Unmapped addresses read 0; writes to them are ignored.
- Events are sampled only in IDLE with I_valid=1. Priority, highest first:
  1. Interrupt: I_irq_ext & MIE & MEIE; mcause 0x8000000B, mtval 0.
  2. Illegal: mcause 2, mtval 0.
  3. ECALL: mcause 11.
  4. EBREAK: mcause 3.
  5. Misalign: mcause 4, mtval = I_badaddr.
  6. MRET.
  - ECALL and EBREAK set mtval to 0.
- Trap entry at edge N:
  - mepc <= I_pc; mcause and mtval per table above.
  - MPIE <= MIE; MIE <= 0.
  - Go to TRAP.
- TRAP (cycle N+1):
  - O_exception = 1, O_stall = 1.
  - O_mevect = mtvec base {mtvec[31:2],2'b00}, or vectored address (see Optional Feature).
  - Next: FLUSH.
- MRET at edge N:
  - MIE <= MPIE; MPIE <= 1.
  - Go to RETURN: O_privsel = 1 and O_stall = 1 for one cycle; then FLUSH.
- FLUSH:
  - O_stall = 1 for FLUSH_CYCLES-1 further cycles (down-counter), then IDLE.
  - Total stall is FLUSH_CYCLES cycles, counted from cycle N+1.
- O_exception and O_privsel are never high together; each lasts exactly one cycle.
- A CSR write in the same cycle as trap entry or MRET is dropped; the trap/MRET update wins.
- CSR writes are accepted only in IDLE.
- I_valid outside IDLE is ignored.
- I_irq_ext is sampled only at retirement. Deasserting it before a retire means no trap.
- O_mepc = mepc register at all times.

Optional Feature:
- Macro: TRAP_VECTORED_EN.
- Defined:
  - mtvec[1:0] writable; mode 1 = vectored.
  - In vectored mode, interrupts go to base + 4*cause[30:0], e.g. base + 0x2C for external.
  - Exceptions always go to base.
- Undefined:
  - mtvec[1:0] reads 0 and ignores writes.
  - All traps go to base.

Test Plan:
- Reset: I_rst high mid-FLUSH → all outputs 0 immediately; mtvec reads 0x00000004 after release.
- ECALL at I_pc=0x100 → next cycle O_exception=1, O_mevect=0x4; mepc=0x100, mcause=11, mtval=0; MIE 1→0 with MPIE=1; O_stall high 2 cycles.
- Misalign with I_badaddr=0x2003 plus simultaneous illegal → mcause=2, mtval=0 (illegal wins).
- Interrupts: mie=0x800, mstatus=0x8, I_irq_ext=1, retire at 0x200 → mcause=0x8000000B, mepc=0x200; with MIE=0 → no trap.
- MRET after trap → O_privsel pulse 1 cycle, O_mepc=0x200, MIE restored to 1, MPIE=1; CSR write to 0x341 in the same cycle ignored.
- TRAP_VECTORED_EN: mtvec=0x1001, external IRQ → O_mevect=0x102C; ECALL → 0x1000; macro undefined → mtvec reads 0x1000.
